// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, sampled with an OVERSAMPLE-times baud tick.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> one even-parity bit is expected between the data and stop bits
//   undefined -> plain 8N1 framing
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   baud_tick     one-clk pulse, OVERSAMPLE pulses per bit period
//   rx_serial     asynchronous serial line, idle high
//   rx_ready      consumer accepts rx_data when high together with rx_valid
//   rx_data       last received byte, held until the next delivery
//   rx_valid      byte available, held until accepted
//   rx_frame_err  one-clk pulse on a bad stop bit (or bad parity)
//   rx_overrun    one-clk pulse when a byte lands while rx_valid is still high
//   rx_busy       high whenever the receiver is not idle
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for a low sample
// START     | counting to mid start bit to reject glitches
// DATA      | sampling DATA_BITS data bits, LSB first
// PARITY    | sampling the even-parity bit (parity build only)
// STOP      | sampling the stop bit, delivering or flagging the frame
// WAIT_HIGH | bad stop bit seen; waiting for the line to return high

module uart_rx #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx_serial,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  sync_meta, rxs;
    logic                  deliver, frame_err;
`ifdef UART_RX_PARITY_EN
    logic                  par_q, par_d;
`endif

    // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            rxs       <= 1'b1;
        end else begin
            sync_meta <= rx_serial;
            rxs       <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        deliver   = 1'b0;
        frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
`endif
        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MID) begin
                        cnt_d = '0;
                        idx_d = '0;
                        // A high sample at mid start bit means the low was a glitch.
                        state_d = rxs ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_TOP) begin
                        shift_d = DATA_BITS'({rxs, shift_q} >> 1);
                        idx_d   = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_TOP) begin
                        par_d   = rxs;
                        state_d = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_TOP) begin
`ifdef UART_RX_PARITY_EN
                        deliver   = rxs && ((^shift_q) == par_q);
`else
                        deliver   = rxs;
`endif
                        frame_err = !deliver;
                        // A low stop bit may be a break; wait for idle before rearming.
                        state_d   = rxs ? S_IDLE : S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output handshake: a new delivery takes priority over an accept in the same clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= frame_err;
            rx_overrun   <= 1'b0;
            if (deliver) begin
                rx_data    <= shift_q;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid && !rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BIT_CLK = 32;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PARITY = 1'b1;
`else
    localparam bit HAS_PARITY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx_serial = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Event counters maintained by the monitor; the main sequence only snapshots them.
    int         mon_rise = 0;
    int         mon_valid_hi = 0;
    int         mon_ferr = 0;
    int         mon_ovr = 0;
    int         mon_wide = 0;
    logic [7:0] mon_last = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;
    logic       prev_ovr = 1'b0;

    int b_rise, b_hi, b_ferr, b_ovr;

    uart_rx #(.OVERSAMPLE(8), .DATA_BITS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_tick    (baud_tick),
        .rx_serial    (rx_serial),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            baud_tick = (div == 3);
            div = (div + 1) % 4;
        end
    end

    always @(negedge clk) begin
        prev_valid <= rx_valid;
        prev_ferr  <= rx_frame_err;
        prev_ovr   <= rx_overrun;
        if (rx_valid) mon_valid_hi <= mon_valid_hi + 1;
        if (rx_valid && !prev_valid) begin
            mon_rise <= mon_rise + 1;
            mon_last <= rx_data;
        end
        if (rx_frame_err) mon_ferr <= mon_ferr + 1;
        if (rx_overrun) mon_ovr <= mon_ovr + 1;
        if ((rx_frame_err && prev_ferr) || (rx_overrun && prev_ovr)) mon_wide <= mon_wide + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_rise = mon_rise;
        b_hi   = mon_valid_hi;
        b_ferr = mon_ferr;
        b_ovr  = mon_ovr;
    endtask

    // Whole frame at BIT_CLK clocks per bit; flip inverts the even-parity bit.
    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
        rx_serial = 1'b0;
        idle_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            idle_clk(BIT_CLK);
        end
        if (HAS_PARITY) begin
            rx_serial = (^d) ^ flip;
            idle_clk(BIT_CLK);
        end
        rx_serial = stop;
        idle_clk(BIT_CLK);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, rx_data, 0);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_ferr"}, rx_frame_err, 0);
        check({tag, "_ovr"}, rx_overrun, 0);
        check({tag, "_busy"}, rx_busy, 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] d;
        logic       stop, flip, good;
        int         gap;

        rst_n = 1'b0;
        idle_clk(5);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle_clk(40);

        // Single byte with consumer always ready.
        rx_ready = 1'b1;
        snap();
        send_frame(8'h41, 1'b0, 1'b1);
        idle_clk(64);
        check("t1_rise", mon_rise - b_rise, 1);
        check("t1_data", mon_last, 8'h41);
        check("t1_valid_width", mon_valid_hi - b_hi, 1);
        check("t1_ferr", mon_ferr - b_ferr, 0);
        check("t1_ovr", mon_ovr - b_ovr, 0);
        check("t1_busy", rx_busy, 0);

        // Back-to-back frames with no consumer: overrun on the second.
        rx_ready = 1'b0;
        snap();
        send_frame(8'hA5, 1'b0, 1'b1);
        check("t2_valid_first", rx_valid, 1);
        check("t2_data_first", rx_data, 8'hA5);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle_clk(8);
        check("t2_valid_second", rx_valid, 1);
        check("t2_data_second", rx_data, 8'h3C);
        check("t2_ovr_count", mon_ovr - b_ovr, 1);
        check("t2_rise", mon_rise - b_rise, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        check("t2_valid_cleared", rx_valid, 0);
        idle_clk(32);

        // Bad stop bit followed by a held-low line.
        snap();
        send_frame(8'h55, 1'b0, 1'b0);
        idle_clk(3 * BIT_CLK);
        check("t3_busy_wait_high", rx_busy, 1);
        check("t3_ferr", mon_ferr - b_ferr, 1);
        check("t3_rise", mon_rise - b_rise, 0);
        rx_serial = 1'b1;
        idle_clk(64);
        check("t3_busy_after_high", rx_busy, 0);
        snap();
        send_frame(8'h12, 1'b0, 1'b1);
        idle_clk(64);
        check("t3_next_rise", mon_rise - b_rise, 1);
        check("t3_next_data", mon_last, 8'h12);
        check("t3_next_ferr", mon_ferr - b_ferr, 0);

        // Short low glitch must be rejected at mid start bit.
        snap();
        rx_serial = 1'b0;
        idle_clk(8);
        rx_serial = 1'b1;
        idle_clk(24);
        check("t4_busy", rx_busy, 0);
        idle_clk(64);
        check("t4_rise", mon_rise - b_rise, 0);
        check("t4_ferr", mon_ferr - b_ferr, 0);

        // Reset in the middle of a 0xFF frame.
        snap();
        rx_serial = 1'b0;
        idle_clk(BIT_CLK);
        rx_serial = 1'b1;
        idle_clk(80);
        rst_n = 1'b0;
        idle_clk(2);
        check_outputs_zero("t5_reset");
        idle_clk(3);
        rst_n = 1'b1;
        idle_clk(400);
        check("t5_no_ff", mon_rise - b_rise, 0);
        snap();
        send_frame(8'h81, 1'b0, 1'b1);
        idle_clk(64);
        check("t5_rise", mon_rise - b_rise, 1);
        check("t5_data", mon_last, 8'h81);
        check("t5_ferr", mon_ferr - b_ferr, 0);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h03, 1'b0, 1'b1);
        idle_clk(64);
        check("t6_good_rise", mon_rise - b_rise, 1);
        check("t6_good_data", mon_last, 8'h03);
        check("t6_good_ferr", mon_ferr - b_ferr, 0);
        snap();
        send_frame(8'h03, 1'b1, 1'b1);
        idle_clk(64);
        check("t6_bad_rise", mon_rise - b_rise, 0);
        check("t6_bad_ferr", mon_ferr - b_ferr, 1);
`endif

        // Random frames against a frame-level model: a frame is delivered exactly
        // when its stop bit is high and (if present) its parity bit is correct.
        for (int k = 0; k < 24; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            flip = HAS_PARITY ? ($urandom_range(0, 3) == 0) : 1'b0;
            gap  = $urandom_range(1, 3) * BIT_CLK;
            good = stop && !(HAS_PARITY && flip);
            snap();
            send_frame(d, flip, stop);
            rx_serial = 1'b1;
            idle_clk(gap + 16);
            check("rnd_rise", mon_rise - b_rise, good ? 1 : 0);
            check("rnd_ferr", mon_ferr - b_ferr, good ? 0 : 1);
            if (good) check("rnd_data", mon_last, d);
            check("rnd_busy", rx_busy, 0);
        end

        check("pulse_width", mon_wide, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
